io_core_param: RTL and testbench
================================

# io_core_param

Parametrised memory-mapped IO core on the manta pipelined register bus. Exposes N_IN input probe channels and N_OUT output probe channels to the host. Adds input synchronisers, strobe-qualified snapshot/update, and per-bit sticky change flags with clear-on-read. It sits in the bus chain between the interface core (UART/Ethernet) and other cores, replacing the fixed-port IO core used for button, switch and LED boards.

## Interface
- BASE_ADDR, 0: first bus address owned by the core.
- N_IN, 4: number of input channels, 1..16.
- IN_WIDTH, 16: bits per input channel, 1..16.
- N_OUT, 4: number of output channels, 1..16.
- OUT_WIDTH, 16: bits per output channel, 1..16.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_i / data_i  in  16 / 16  incoming bus address and write data.
- rw_i  in  1  1 = write, 0 = read.
- valid_i  in  1  bus transaction qualifier.
- addr_o / data_o  out  16 / 16  outgoing bus address and data.
- rw_o / valid_o  out  1 / 1  registered copies of rw_i and valid_i.
- probes_in  in  N_IN*IN_WIDTH  asynchronous inputs; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- probes_out  out  N_OUT*OUT_WIDTH  registered outputs; packed in the same way.

## Operation
- Register map, as offsets from BASE_ADDR:
  - 0: strobe. Bit0 is the snapshot/update strobe. Bit1 is the clear-all-flags strobe. Read/write.
  - 1..N_IN: input buffer for channel k-1. Read-only.
  - N_IN+1..2*N_IN: sticky change flags for channel k-1. Read returns the flags, then clears them.
  - 2*N_IN+1..2*N_IN+N_OUT: output buffer for channel k-1. Read/write.
- Reads return unused upper bits as 0. Writes keep only the low OUT_WIDTH bits.
- Writes to read-only offsets are ignored.
- Addresses outside the core's range, and all writes, pass data_i through unchanged.
- Input path:
  - Each probes_in bit passes through a 2-flop synchroniser, giving sync.
  - A third register, prev, holds the previous sync value.
  - A flag bit sets on any cycle where sync != prev.
- Strobe action: on a 0->1 transition of strobe bit0 (compared with its previous-cycle value):
  - input buffers <= sync;
  - probes_out <= output buffers.
  - Holding bit0 at 1 or rewriting 1 causes no further action. The host must write 0 and then 1 to re-strobe.
- Strobe bit1: a 0->1 transition clears all flags. A change that sets a flag in the same cycle wins.
- Flag clear-on-read: flags for the addressed channel clear on the edge that accepts the read. Bits newly set in that same cycle remain set.
- Reset values, all 0: strobe, input buffers, output buffers, synchronisers, prev, flags, probes_out, addr_o, data_o, rw_o, valid_o.
  - Consequence: an input held high through reset sets its flag bits once, after synchronisation.

## Timing
- Bus latency is fixed at 1 cycle. Transaction accepted at edge E0 appears on the *_o outputs after E0. There is no backpressure, and back-to-back transactions are supported every cycle.
- Read data is the register value as of the cycle before E0. A write at E0 is visible to a read accepted at E1.
- Strobe write accepted at E0: the edge is detected and acted on at E1. probes_out changes and input buffers update after E1.
- Input to flag: a probes_in change sets the flag after 3 edges (2 synchroniser edges plus the compare edge). It is readable by a read accepted at the following edge.
- Asynchronous rst asserted mid-transaction: all state clears immediately. valid_o drops without waiting for clk. The in-flight transaction is lost.

## Test plan
All scenarios use default parameters: offsets 0 strobe, 1-4 inputs, 5-8 flags, 9-12 outputs.
- Reset: rst=1, then release -> all outputs 0; read offset 9 returns 0x0000; probes_out = 0.
- Output update: write 0xBEEF to offset 9, strobe 0 then 1 -> probes_out[15:0] = 0xBEEF exactly 2 cycles after the strobe-1 write. Before the strobe it stays 0. A second strobe-1 write without writing 0 leaves a new buffer value unapplied.
- Input snapshot: drive probes_in[31:16]=0x1234, wait 4 cycles, strobe -> read offset 2 returns 0x1234. Change the input to 0x5678 without a strobe -> read still returns 0x1234.
- Sticky flags:
  - Toggle probes_in bit 3 high then low -> read offset 5 returns 0x0008; an immediate re-read returns 0x0000.
  - A toggle of the same bit landing on the read-accept edge -> the bit is still 1 on the next read.
- Pass-through and latency: read offset 13 with data_i=0xA5A5 -> data_o=0xA5A5 one cycle later. Back-to-back reads of offsets 1-12 give valid_o high for 12 consecutive cycles.
- Async reset mid-stream: assert rst between edges during a write burst -> probes_out and valid_o go 0 before the next clk edge. The post-reset read of offset 9 returns 0.

Source files
------------

// File: rtl/io_core_param.sv
// io_core_param
//   Memory-mapped IO core on the pipelined register bus. Exposes N_IN input
//   probe channels (synchronised, snapshot on strobe, sticky change flags with
//   clear-on-read) and N_OUT output probe channels (buffered, applied to
//   probes_out on strobe).
//
// Register map (offsets from BASE_ADDR):
//   0                          strobe: bit0 snapshot/update, bit1 clear-all-flags
//   1 .. N_IN                  input buffer, channel k-1 (read-only)
//   N_IN+1 .. 2*N_IN           sticky change flags, channel k-1 (clear-on-read)
//   2*N_IN+1 .. 2*N_IN+N_OUT   output buffer, channel k-1 (read/write)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr_i, data_i           incoming bus address / write data
//   rw_i, valid_i            1 = write / transaction qualifier
//   addr_o, data_o           outgoing bus address / data (1-cycle latency)
//   rw_o, valid_o            registered copies of rw_i / valid_i
//   probes_in                asynchronous inputs, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   probes_out               registered outputs, channel k at [k*OUT_WIDTH +: OUT_WIDTH]
module io_core_param #(
   parameter int BASE_ADDR = 0,
   parameter int N_IN      = 4,
   parameter int IN_WIDTH  = 16,
   parameter int N_OUT     = 4,
   parameter int OUT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                addr_i,
   input  logic [15:0]                data_i,
   input  logic                       rw_i,
   input  logic                       valid_i,
   output logic [15:0]                addr_o,
   output logic [15:0]                data_o,
   output logic                       rw_o,
   output logic                       valid_o,
   input  logic [N_IN*IN_WIDTH-1:0]   probes_in,
   output logic [N_OUT*OUT_WIDTH-1:0] probes_out
);

   localparam int          IW      = N_IN * IN_WIDTH;
   localparam int          OW      = N_OUT * OUT_WIDTH;
   localparam int          MAX_OFF = 2 * N_IN + N_OUT;
   localparam logic [15:0] BASE    = 16'(BASE_ADDR);

   // Zero-extend an input channel onto the 16-bit bus.
   function automatic logic [15:0] in_to_bus(input logic [IN_WIDTH-1:0] v);
      logic [15:0] r;
      r = '0;
      r[IN_WIDTH-1:0] = v;
      return r;
   endfunction

   // Zero-extend an output channel onto the 16-bit bus.
   function automatic logic [15:0] out_to_bus(input logic [OUT_WIDTH-1:0] v);
      logic [15:0] r;
      r = '0;
      r[OUT_WIDTH-1:0] = v;
      return r;
   endfunction

   // Keep only the low OUT_WIDTH bits of a bus write.
   function automatic logic [OUT_WIDTH-1:0] bus_to_out(input logic [15:0] d);
      return d[OUT_WIDTH-1:0];
   endfunction

   logic [1:0]    strobe;
   logic [1:0]    strobe_prev;
   logic [IW-1:0] sync_p0;
   logic [IW-1:0] sync_p1;
   logic [IW-1:0] prev_p2;
   logic [IW-1:0] flags;
   logic [IW-1:0] in_buf;
   logic [OW-1:0] out_buf;

   logic [15:0]   off;
   logic          in_range;
   logic          rd_en;
   logic          wr_en;
   logic [15:0]   rd_data;
   logic [IW-1:0] clr_mask;
   logic [IW-1:0] chg;
   logic [IW-1:0] flags_n;
   logic          strb_rise;
   logic          clr_rise;

   // Address decode and read mux (register values as of before this edge)
   always_comb begin
      off      = addr_i - BASE;
      in_range = (addr_i >= BASE) && (off <= 16'(MAX_OFF));
      rd_en    = valid_i & ~rw_i & in_range;
      wr_en    = valid_i & rw_i & in_range;
      rd_data  = '0;
      clr_mask = '0;
      if (off == 16'd0) rd_data = {14'b0, strobe};
      for (int k = 0; k < N_IN; k++) begin
         if (off == 16'(k + 1)) rd_data = in_to_bus(in_buf[k*IN_WIDTH +: IN_WIDTH]);
         if (off == 16'(N_IN + 1 + k)) begin
            rd_data = in_to_bus(flags[k*IN_WIDTH +: IN_WIDTH]);
            if (rd_en) clr_mask[k*IN_WIDTH +: IN_WIDTH] = '1;
         end
      end
      for (int k = 0; k < N_OUT; k++) begin
         if (off == 16'(2 * N_IN + 1 + k)) rd_data = out_to_bus(out_buf[k*OUT_WIDTH +: OUT_WIDTH]);
      end
   end

   // Flag update: a change seen this cycle always survives a clear, whether
   // the clear comes from the clear-all strobe or from a flag read.
   always_comb begin
      chg       = sync_p1 ^ prev_p2;
      strb_rise = strobe[0] & ~strobe_prev[0];
      clr_rise  = strobe[1] & ~strobe_prev[1];
      if (clr_rise) flags_n = chg;
      else          flags_n = (flags & ~clr_mask) | chg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_o      <= '0;
         data_o      <= '0;
         rw_o        <= 1'b0;
         valid_o     <= 1'b0;
         strobe      <= '0;
         strobe_prev <= '0;
         sync_p0     <= '0;
         sync_p1     <= '0;
         prev_p2     <= '0;
         flags       <= '0;
         in_buf      <= '0;
         out_buf     <= '0;
         probes_out  <= '0;
      end else begin
         // Bus stage: everything not read from this core passes through
         addr_o  <= addr_i;
         rw_o    <= rw_i;
         valid_o <= valid_i;
         data_o  <= rd_en ? rd_data : data_i;

         // Input stages: two synchroniser flops, then the compare register
         sync_p0 <= probes_in;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         flags   <= flags_n;

         strobe_prev <= strobe;
         if (wr_en && off == 16'd0) strobe <= data_i[1:0];
         for (int k = 0; k < N_OUT; k++) begin
            if (wr_en && off == 16'(2 * N_IN + 1 + k))
               out_buf[k*OUT_WIDTH +: OUT_WIDTH] <= bus_to_out(data_i);
         end

         // Strobe stage: act one edge after the strobe register rises
         if (strb_rise) begin
            in_buf     <= sync_p1;
            probes_out <= out_buf;
         end
      end
   end

endmodule

// File: tb/tb_io_core_param.sv
module tb_io_core_param;

   logic        clk;
   logic        rst;
   logic [15:0] addr_i;
   logic [15:0] data_i;
   logic        rw_i;
   logic        valid_i;
   logic [15:0] addr_o;
   logic [15:0] data_o;
   logic        rw_o;
   logic        valid_o;
   logic [63:0] probes_in;
   logic [63:0] probes_out;

   int n_total;
   int n_pass;

   io_core_param #(
      .BASE_ADDR(0),
      .N_IN(4),
      .IN_WIDTH(16),
      .N_OUT(4),
      .OUT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr_i(addr_i),
      .data_i(data_i),
      .rw_i(rw_i),
      .valid_i(valid_i),
      .addr_o(addr_o),
      .data_o(data_o),
      .rw_o(rw_o),
      .valid_o(valid_o),
      .probes_in(probes_in),
      .probes_out(probes_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      logic [15:0] exp_pout0;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Drive one bus cycle, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic rw, input logic [15:0] a, input logic [15:0] d);
      valid_i = v;
      rw_i    = rw;
      addr_i  = a;
      data_i  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      n_total   = 0;
      n_pass    = 0;
      rst       = 1'b1;
      valid_i   = 1'b0;
      rw_i      = 1'b0;
      addr_i    = '0;
      data_i    = '0;
      probes_in = '0;

      //            rw    addr   wdata    exp_data exp_pout0
      vecs[0]  = '{1'b0, 16'd9,  16'h0000, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b1, 16'd9,  16'hBEEF, 16'hBEEF, 16'h0000};
      vecs[2]  = '{1'b0, 16'd9,  16'h0000, 16'hBEEF, 16'h0000};
      vecs[3]  = '{1'b1, 16'd0,  16'h0000, 16'h0000, 16'h0000};
      vecs[4]  = '{1'b1, 16'd0,  16'h0001, 16'h0001, 16'h0000};
      vecs[5]  = '{1'b0, 16'd0,  16'h0000, 16'h0001, 16'hBEEF};
      vecs[6]  = '{1'b1, 16'd9,  16'h1111, 16'h1111, 16'hBEEF};
      vecs[7]  = '{1'b1, 16'd0,  16'h0001, 16'h0001, 16'hBEEF};
      vecs[8]  = '{1'b0, 16'd9,  16'h0000, 16'h1111, 16'hBEEF};
      vecs[9]  = '{1'b0, 16'd13, 16'hA5A5, 16'hA5A5, 16'hBEEF};
      vecs[10] = '{1'b0, 16'hFFFF, 16'h5A5A, 16'h5A5A, 16'hBEEF};
      vecs[11] = '{1'b1, 16'd2,  16'h7777, 16'h7777, 16'hBEEF};
      vecs[12] = '{1'b0, 16'd2,  16'h0000, 16'h0000, 16'hBEEF};
      vecs[13] = '{1'b0, 16'd5,  16'h0000, 16'h0000, 16'hBEEF};
      vecs[14] = '{1'b1, 16'd12, 16'h00FF, 16'h00FF, 16'hBEEF};
      vecs[15] = '{1'b0, 16'd12, 16'h0000, 16'h00FF, 16'hBEEF};
      vecs[16] = '{1'b0, 16'd0,  16'h0000, 16'h0001, 16'hBEEF};

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_addr_o", addr_o, 0);
      chk("rst_rw_o", rw_o, 0);
      chk("rst_probes_out", probes_out, 0);
      rst = 1'b0;
      idle(1);

      // Table-driven bus transactions
      for (int i = 0; i < 17; i++) begin
         cyc(1'b1, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_data_o", i), data_o, vecs[i].exp_data);
         chk($sformatf("vec%0d_valid_o", i), valid_o, 1);
         chk($sformatf("vec%0d_addr_o", i), addr_o, vecs[i].addr);
         chk($sformatf("vec%0d_rw_o", i), rw_o, vecs[i].rw);
         chk($sformatf("vec%0d_pout0", i), probes_out[15:0], vecs[i].exp_pout0);
      end

      // Input snapshot; the same strobe applies the pending output buffers
      probes_in[31:16] = 16'h1234;
      idle(4);
      cyc(1'b1, 1'b1, 16'd0, 16'h0000);
      cyc(1'b1, 1'b1, 16'd0, 16'h0001);
      chk("snap_pout_before", probes_out, 64'h0000_0000_0000_BEEF);
      idle(1);
      chk("snap_pout_after", probes_out, 64'h00FF_0000_0000_1111);
      cyc(1'b1, 1'b0, 16'd2, 16'h0000);
      chk("snap_rd2", data_o, 16'h1234);
      probes_in[31:16] = 16'h5678;
      idle(4);
      cyc(1'b1, 1'b0, 16'd2, 16'h0000);
      chk("snap_rd2_hold", data_o, 16'h1234);
      cyc(1'b1, 1'b0, 16'd6, 16'h0000);
      chk("flag_ch1", data_o, 16'h567C);
      cyc(1'b1, 1'b0, 16'd6, 16'h0000);
      chk("flag_ch1_cleared", data_o, 16'h0000);

      // Sticky flag: one-cycle pulse on bit 3
      probes_in[3] = 1'b1;
      idle(1);
      probes_in[3] = 1'b0;
      idle(5);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("flag_pulse", data_o, 16'h0008);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("flag_pulse_reread", data_o, 16'h0000);

      // Change landing on the read-accept edge survives the clear
      probes_in[3] = 1'b1;
      idle(2);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("flag_race_read", data_o, 16'h0000);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("flag_race_kept", data_o, 16'h0008);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("flag_race_cleared", data_o, 16'h0000);

      // Clear-all strobe
      probes_in[0] = 1'b1;
      idle(5);
      cyc(1'b1, 1'b1, 16'd0, 16'h0000);
      cyc(1'b1, 1'b1, 16'd0, 16'h0002);
      idle(1);
      cyc(1'b1, 1'b0, 16'd5, 16'h0000);
      chk("clear_all_flags", data_o, 16'h0000);
      cyc(1'b1, 1'b0, 16'd0, 16'h0000);
      chk("strobe_rd", data_o, 16'h0002);

      // Back-to-back reads of offsets 1..12
      for (int a = 1; a <= 12; a++) begin
         cyc(1'b1, 1'b0, 16'(a), 16'h0000);
         chk($sformatf("b2b%0d_valid", a), valid_o, 1);
         chk($sformatf("b2b%0d_addr", a), addr_o, 16'(a));
      end
      idle(1);
      chk("b2b_end_valid", valid_o, 0);

      // Asynchronous reset in the middle of a write burst
      cyc(1'b1, 1'b1, 16'd10, 16'h4321);
      chk("ar_valid_pre", valid_o, 1);
      chk("ar_pout_pre", probes_out, 64'h00FF_0000_0000_1111);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid_o", valid_o, 0);
      chk("ar_probes_out", probes_out, 0);
      chk("ar_data_o", data_o, 0);
      valid_i = 1'b0;
      #1;
      rst = 1'b0;
      idle(1);
      cyc(1'b1, 1'b0, 16'd9, 16'h0000);
      chk("ar_rd9", data_o, 16'h0000);
      cyc(1'b1, 1'b0, 16'd10, 16'h0000);
      chk("ar_rd10", data_o, 16'h0000);
      chk("ar_pout_post", probes_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
